// File: rtl/controller_sequencer_pkg.sv
// Shared controller constants: micro-op numbering, ISA widths, sequencer states.
// The microcode ROM uses the same uOP constants.
package controller_sequencer_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned UOP_W     = 3;
    localparam int unsigned RETIRED_W = 16;
    localparam int unsigned STATE_W   = 2;
    localparam int unsigned FLAG_W    = 2;

    localparam logic [UOP_W-1:0] UOP_FETCH      = 3'd0;
    localparam logic [UOP_W-1:0] UOP_DECODE     = 3'd1;
    localparam logic [UOP_W-1:0] UOP_EXEC_FIRST = 3'd2;
    localparam logic [UOP_W-1:0] UOP_EXEC_LAST  = 3'd6;
    localparam logic [UOP_W-1:0] UOP_PARK       = 3'd7;

    localparam logic [INSTR_W-1:0] INSTR_NOP = 16'hF000;

    localparam logic [STATE_W-1:0] PARK    = 2'd0;
    localparam logic [STATE_W-1:0] RUN_ST  = 2'd1;
    localparam logic [STATE_W-1:0] STEP_ST = 2'd2;
    localparam logic [STATE_W-1:0] DRAIN   = 2'd3;

    typedef struct packed {
        logic zero;
        logic carry;
    } alu_flags_t;

    // Controller strobes are only trusted in the execute window.
    function automatic logic uop_in_exec(input logic [UOP_W-1:0] uop);
        return (uop >= UOP_EXEC_FIRST) && (uop <= UOP_EXEC_LAST);
    endfunction

endpackage

// File: rtl/controller_flags.sv
// Generic flag register with a load qualifier; holds when load is low.
module controller_flags #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// Sequencer ahead of the microcode ROM: IR, uOP counter, flags, run/step control,
// retired-instruction counter and runaway-microcode watchdog.
module controller_sequencer
    import controller_sequencer_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [INSTR_W-1:0]   BUS_IN,
    input  logic                 IR_LOAD,
    input  logic                 RESET_uOP,
    input  logic                 READ_FLAGS,
    input  logic                 ALU_ZERO,
    input  logic                 ALU_COUT,
    input  logic                 RUN,
    input  logic                 STEP,
    output logic [INSTR_W-1:0]   INSTR,
    output logic [UOP_W-1:0]     uOP,
    output logic                 ZERO_FLAG,
    output logic                 CIN_FLAG,
    output logic                 PARKED,
    output logic                 FAULT,
    output logic [RETIRED_W-1:0] RETIRED
);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [UOP_W-1:0]     uop_q, uop_d;
    logic [INSTR_W-1:0]   instr_q;
    logic                 fault_q, fault_d;
    logic [RETIRED_W-1:0] retired_q, retired_d;
    logic                 in_exec;
    logic                 accept;
    logic                 flags_load;
    alu_flags_t           flags_d, flags_q;

    assign in_exec    = uop_in_exec(uop_q);
    assign accept     = RESET_uOP && in_exec;
    assign flags_load = READ_FLAGS && in_exec;
    assign flags_d    = '{zero: ALU_ZERO, carry: ALU_COUT};

    // Sequencer state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= PARK;
            uop_q     <= UOP_PARK;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            uop_q     <= uop_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    // Next state: start from park, advance uOP, retire, drain or trip the watchdog.
    always_comb begin
        state_d   = state_q;
        uop_d     = uop_q;
        fault_d   = fault_q;
        retired_d = retired_q;
        case (state_q)
            PARK: begin
                if (!fault_q) begin
                    if (RUN) begin
                        state_d = RUN_ST;
                        uop_d   = UOP_FETCH;
                    end else if (STEP) begin
                        state_d = STEP_ST;
                        uop_d   = UOP_FETCH;
                    end
                end
            end
            default: begin
                if (accept) begin
                    retired_d = retired_q + RETIRED_W'(1);
                    if ((state_q == RUN_ST) && RUN) begin
                        uop_d = UOP_FETCH;
                    end else begin
                        state_d = PARK;
                        uop_d   = UOP_PARK;
                    end
                end else if (uop_q == UOP_EXEC_LAST) begin
                    fault_d = 1'b1;
                    state_d = PARK;
                    uop_d   = UOP_PARK;
                end else begin
                    uop_d = uop_q + UOP_W'(1);
                    if ((state_q == RUN_ST) && !RUN) begin
                        state_d = DRAIN;
                    end else if ((state_q == DRAIN) && RUN) begin
                        state_d = RUN_ST;
                    end
                end
            end
        endcase
    end

    // Instruction register; decode slot is the only point the bus carries the opcode.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            instr_q <= INSTR_NOP;
        end else if (IR_LOAD && (uop_q == UOP_DECODE)) begin
            instr_q <= BUS_IN;
        end
    end

    controller_flags #(
        .WIDTH (FLAG_W)
    ) u_flags (
        .clk  (CLK),
        .rst  (RESET),
        .load (flags_load),
        .d    (flags_d),
        .q    (flags_q)
    );

    assign INSTR     = instr_q;
    assign uOP       = uop_q;
    assign ZERO_FLAG = flags_q.zero;
    assign CIN_FLAG  = flags_q.carry;
    assign PARKED    = (state_q == PARK);
    assign FAULT     = fault_q;
    assign RETIRED   = retired_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: directed scenarios plus random
// stimulus against an instruction-level reference model.
`timescale 1ns/1ps
module tb_controller_sequencer;

    logic        CLK;
    logic        RESET;
    logic [15:0] BUS_IN;
    logic        IR_LOAD, RESET_uOP, READ_FLAGS, ALU_ZERO, ALU_COUT, RUN, STEP;
    logic [15:0] INSTR;
    logic [2:0]  uOP;
    logic        ZERO_FLAG, CIN_FLAG, PARKED, FAULT;
    logic [15:0] RETIRED;

    controller_sequencer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BUS_IN     (BUS_IN),
        .IR_LOAD    (IR_LOAD),
        .RESET_uOP  (RESET_uOP),
        .READ_FLAGS (READ_FLAGS),
        .ALU_ZERO   (ALU_ZERO),
        .ALU_COUT   (ALU_COUT),
        .RUN        (RUN),
        .STEP       (STEP),
        .INSTR      (INSTR),
        .uOP        (uOP),
        .ZERO_FLAG  (ZERO_FLAG),
        .CIN_FLAG   (CIN_FLAG),
        .PARKED     (PARKED),
        .FAULT      (FAULT),
        .RETIRED    (RETIRED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] instr;
        logic [2:0]  uop;
        logic        zf;
        logic        cf;
        logic        parked;
        logic        fault;
        logic [15:0] retired;
        logic [7:0]  tag;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: an instruction is "in flight" (m_busy) and either a one-shot
    // step or a run-mode instruction that keeps going while RUN stays high.
    logic [15:0] m_instr;
    int          m_uop;
    bit          m_zf, m_cf, m_fault, m_busy, m_one_shot, m_run_prev;
    int unsigned m_retired;
    logic [7:0]  cur_tag;

    task automatic model_reset();
        m_instr    = 16'hF000;
        m_uop      = 7;
        m_zf       = 0;
        m_cf       = 0;
        m_fault    = 0;
        m_busy     = 0;
        m_one_shot = 0;
        m_run_prev = 0;
        m_retired  = 0;
    endtask

    task automatic model_step();
        bit exec;
        if (RESET) begin
            model_reset();
            return;
        end
        exec = (m_uop >= 2) && (m_uop <= 6);
        if (IR_LOAD && m_uop == 1) m_instr = BUS_IN;
        if (READ_FLAGS && exec) begin
            m_zf = ALU_ZERO;
            m_cf = ALU_COUT;
        end
        if (!m_busy) begin
            if (!m_fault && (RUN || STEP)) begin
                m_busy     = 1;
                m_one_shot = !RUN;
                m_run_prev = 1;
                m_uop      = 0;
            end
        end else if (RESET_uOP && exec) begin
            m_retired = (m_retired + 1) % 65536;
            if (!m_one_shot && m_run_prev && RUN) begin
                m_uop = 0;
            end else begin
                m_busy = 0;
                m_uop  = 7;
            end
        end else if (m_uop == 6) begin
            m_fault = 1;
            m_busy  = 0;
            m_uop   = 7;
        end else begin
            m_uop = m_uop + 1;
            if (!m_one_shot) m_run_prev = RUN;
        end
    endtask

    function automatic obs_t snap();
        obs_t s;
        s.instr   = m_instr;
        s.uop     = 3'(m_uop);
        s.zf      = m_zf;
        s.cf      = m_cf;
        s.parked  = !m_busy;
        s.fault   = m_fault;
        s.retired = 16'(m_retired);
        s.tag     = cur_tag;
        return s;
    endfunction

    task automatic replace_last();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(snap());
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic run, input logic step, input logic ruop, input logic irl,
                         input logic rf, input logic [15:0] bus, input logic az, input logic ac);
        RUN = run; STEP = step; RESET_uOP = ruop; IR_LOAD = irl;
        READ_FLAGS = rf; BUS_IN = bus; ALU_ZERO = az; ALU_COUT = ac;
        @(posedge CLK);
        #1;
        model_step();
        exp_q.push_back(snap());
    endtask

    task automatic idle(input logic run);
        cycle(run, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    // Called at posedge+1; asserts reset asynchronously and checks its immediate effect.
    task automatic do_reset();
        RESET = 1'b1;
        model_reset();
        replace_last();
        #1;
        check("async_reset_instr",  32'(INSTR),   32'h0000F000);
        check("async_reset_uop",    32'(uOP),     32'd7);
        check("async_reset_parked", 32'(PARKED),  32'd1);
        check("async_reset_fault",  32'(FAULT),   32'd0);
        check("async_reset_ret",    32'(RETIRED), 32'd0);
        check("async_reset_flags",  32'({ZERO_FLAG, CIN_FLAG}), 32'd0);
        idle(1'b0);
        RESET = 1'b0;
    endtask

    // Monitor: every negedge the DUT presents a new observation to compare.
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                obs_t e;
                obs_t a;
                e = exp_q.pop_front();
                a.instr   = INSTR;
                a.uop     = uOP;
                a.zf      = ZERO_FLAG;
                a.cf      = CIN_FLAG;
                a.parked  = PARKED;
                a.fault   = FAULT;
                a.retired = RETIRED;
                a.tag     = e.tag;
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard phase=%0d t=%0t got instr=%h uop=%0d z=%b c=%b parked=%b fault=%b ret=%0d expected instr=%h uop=%0d z=%b c=%b parked=%b fault=%b ret=%0d",
                             e.tag, $time, a.instr, a.uop, a.zf, a.cf, a.parked, a.fault, a.retired,
                             e.instr, e.uop, e.zf, e.cf, e.parked, e.fault, e.retired);
                end
            end
        end
    end

    initial begin
        logic run_lvl;
        RESET = 1'b0; RUN = 0; STEP = 0; RESET_uOP = 0; IR_LOAD = 0;
        READ_FLAGS = 0; BUS_IN = '0; ALU_ZERO = 0; ALU_COUT = 0;
        model_reset();
        cur_tag = 8'd0;
        @(posedge CLK);
        #1;
        do_reset();

        // Run-mode fetch/decode/execute with retire at uOP3.
        cur_tag = 8'd1;
        idle(1'b1);
        check("t1_first_uop", 32'(uOP), 32'd0);
        idle(1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0);
        idle(1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t1_refetch_uop", 32'(uOP),     32'd0);
        check("t1_instr",       32'(INSTR),   32'h0005);
        check("t1_retired",     32'(RETIRED), 32'd1);

        // RUN drops at uOP1: drain to completion, then park.
        cur_tag = 8'd3;
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t3_uop_parked", 32'(uOP),     32'd7);
        check("t3_parked",     32'(PARKED),  32'd1);
        check("t3_retired",    32'(RETIRED), 32'd2);
        idle(1'b0);
        check("t3_no_fetch",   32'(uOP),     32'd7);

        // Single step, second STEP during the instruction ignored.
        cur_tag = 8'd2;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t2_busy", 32'(PARKED), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        idle(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t2_parked",  32'(PARKED),  32'd1);
        check("t2_retired", 32'(RETIRED), 32'd3);
        idle(1'b0);
        check("t2_stays",   32'(uOP),     32'd7);

        // Flag capture in the execute window only.
        cur_tag = 8'd4;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        check("t4_flags_set", 32'({ZERO_FLAG, CIN_FLAG}), 32'd3);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        check("t4_flags_hold", 32'({ZERO_FLAG, CIN_FLAG}), 32'd3);
        idle(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Watchdog: no RESET_uOP through uOP6.
        cur_tag = 8'd5;
        for (int i = 0; i < 7; i++) idle(1'b1);
        check("t5_uop6", 32'(uOP), 32'd6);
        idle(1'b1);
        check("t5_fault",   32'(FAULT),   32'd1);
        check("t5_uop",     32'(uOP),     32'd7);
        check("t5_retired", 32'(RETIRED), 32'd5);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("t5_stuck", 32'(PARKED), 32'd1);

        // RETIRED wrap, then reset mid-instruction.
        cur_tag = 8'd6;
        do_reset();
        force dut.retired_q = 16'hFFFF;
        m_retired = 32'hFFFF;
        replace_last();
        idle(1'b0);
        release dut.retired_q;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t6_wrap", 32'(RETIRED), 32'd0);
        idle(1'b1);
        idle(1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        idle(1'b1);
        check("t6_instr", 32'(INSTR), 32'h1234);
        do_reset();

        // RESET_uOP at uOP6 retires instead of faulting.
        cur_tag = 8'd7;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) idle(1'b0);
        check("t7_uop6", 32'(uOP), 32'd6);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t7_no_fault", 32'(FAULT),   32'd0);
        check("t7_retired",  32'(RETIRED), 32'd1);

        // Random traffic.
        cur_tag = 8'd8;
        run_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) run_lvl = !run_lvl;
            cycle(run_lvl,
                  1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  16'($urandom),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 249) == 0) do_reset();
        end

        @(negedge CLK);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

Sequencing stage directly upstream of the microcode controller ROM. It holds the instruction register, the 3-bit micro-operation counter and the ZERO/CARRY flag register, and it feeds INSTR, uOP, ZERO_FLAG and CIN_FLAG to the controller. It consumes the controller's IR_LOAD, RESET_uOP and READ_FLAGS strobes, and adds run/step control, a retired-instruction counter and a runaway-microcode watchdog.

## Interface
- No parameters. Widths are fixed by the ISA: 16-bit instruction and 3-bit uOP.
- CLK  in  1  system clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-high reset
- BUS_IN  in  16  data bus; source of the instruction word during decode
- IR_LOAD  in  1  from controller: capture BUS_IN into the IR
- RESET_uOP  in  1  from controller: the current instruction is complete
- READ_FLAGS  in  1  from controller: capture the ALU flags
- ALU_ZERO  in  1  ALU zero result
- ALU_COUT  in  1  ALU carry out
- RUN  in  1  level; free-run while high
- STEP  in  1  one-cycle pulse; execute exactly one instruction while parked
- INSTR  out  16  IR contents, to controller
- uOP  out  3  current micro-operation, to controller
- ZERO_FLAG  out  1  latched zero flag
- CIN_FLAG  out  1  latched carry flag
- PARKED  out  1  high while uOP==7 and no instruction is in progress
- FAULT  out  1  sticky watchdog fault
- RETIRED  out  16  count of completed instructions

## Operation
- **Reset values:** INSTR=16'hF000 (NOP), uOP=7, ZERO_FLAG=0, CIN_FLAG=0, PARKED=1, FAULT=0, RETIRED=0, FSM=PARK.
- **FSM states:**
  - PARK: uOP held at 7.
  - RUN_ST: free-running.
  - STEP_ST: one instruction, then back to PARK.
  - DRAIN: RUN dropped mid-instruction; finish the instruction, then PARK.
- **PARK transitions:**
  - RUN=1 → RUN_ST, uOP←0.
  - Else STEP=1 → STEP_ST, uOP←0.
  - FAULT=1 keeps the block in PARK regardless of RUN/STEP.
- **Inside an instruction:** uOP increments 0→1→2… each cycle.
- **RESET_uOP:** sampled only when uOP∈{2..6}. It is ignored at 0, 1 and 7 because the controller output may hold a stale value. When accepted:
  - RETIRED+1, wrapping 16'hFFFF→0.
  - In RUN_ST with RUN=1: next uOP=0.
  - In RUN_ST with RUN=0, in DRAIN, or in STEP_ST: next uOP=7 and FSM=PARK.
- **RUN falling** in RUN_ST while uOP≠7 → DRAIN. RUN rising again during DRAIN → back to RUN_ST with no bubble.
- **Watchdog:** uOP==6 without an accepted RESET_uOP → FAULT←1, uOP←7, PARK. RETIRED is not incremented. FAULT clears only on RESET.
- **IR:** INSTR←BUS_IN on any edge with IR_LOAD=1 and uOP==1. IR_LOAD at any other uOP is ignored.
- **Flags:** ZERO_FLAG←ALU_ZERO and CIN_FLAG←ALU_COUT on edges with READ_FLAGS=1 and uOP∈{2..6}. Otherwise they hold.
- **STEP during RUN_ST, STEP_ST or DRAIN:** ignored.

## Timing
- All outputs are registered. The controller sees a new uOP one cycle after the strobe that caused it.
- Park-to-fetch latency: one edge after RUN/STEP is sampled high.
- Minimum instruction length: 3 cycles (uOP 0,1,2 with RESET_uOP at 2). The next fetch is at the following edge, with no idle cycle in RUN_ST.
- **Simultaneous events on one edge:**
  - RESET_uOP + READ_FLAGS: both take effect.
  - RESET_uOP at uOP 6: the instruction retires; the watchdog does not fire.
- **RESET mid-instruction:** immediate asynchronous return to all reset values. No retire count; the IR is forced to NOP.
- PARKED is combinational from registered state only (FSM==PARK). It never depends on inputs.

## Structure
- **Shared controller package:**
  - Constants: UOP_FETCH=3'd0, UOP_DECODE=3'd1, UOP_EXEC_FIRST=3'd2, UOP_EXEC_LAST=3'd6, UOP_PARK=3'd7, INSTR_NOP=16'hF000.
  - FSM state enumeration: PARK, RUN_ST, STEP_ST, DRAIN.
  - The controller ROM uses the same uOP constants.
- **Sub-module `controller_flags`:** a 2-bit flag register with a load qualifier. It is reusable for future flags.
- Everything else lives inline: FSM, uOP counter, IR, RETIRED counter.

## Test plan
- Reset, then RUN=1, BUS_IN=16'h0005 with IR_LOAD at uOP1, RESET_uOP at uOP3 → uOP 7,0,1,2,3,0; INSTR=16'h0005; RETIRED=1.
- Parked, STEP pulse, RESET_uOP at uOP2 → uOP 0,1,2,7; PARKED high again; RETIRED=1; a second STEP during the instruction is ignored.
- RUN drops at uOP1, RESET_uOP at uOP4 → instruction finishes (DRAIN); uOP=7 next; no new fetch.
- READ_FLAGS at uOP4 with ALU_ZERO=1, ALU_COUT=1 → both flags 1 next cycle; READ_FLAGS at uOP0 with ALU_ZERO=0 → flags unchanged.
- Never assert RESET_uOP → at uOP6, FAULT=1 next edge, uOP=7, RETIRED unchanged; RUN held high stays parked until RESET.
- Preload RETIRED to 16'hFFFF via 65535 one-instruction cycles (or force), retire once → RETIRED=0; assert RESET at uOP3 → INSTR=16'hF000, uOP=7 immediately.
